// File: rtl/vga_timing_generator.sv
// VGA raster timing: nested h/v counters with registered sync/video/strobe decode; optional VGA_TIMING_FRAMECOUNT_EN adds a 16-bit frame counter.
// Decoded outputs share the counter register stage; Enable low freezes every register.
module vga_timing_generator #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 12
) (
    input  logic             pixelClk,
    input  logic             rst,
    input  logic             Enable,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             videoOn,
    output logic             lineEnd,
    output logic             frameEnd
`ifdef VGA_TIMING_FRAMECOUNT_EN
    ,
    output logic [15:0]      frameCount
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            CNT_W < 1 || CNT_W > 30 ||
            (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_params
            $fatal(1, "vga_timing_generator: illegal timing parameters for CNT_W");
        end
    endgenerate

    // Every region boundary is below H_TOTAL/V_TOTAL, so all fit in CNT_W bits.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             line_end_q, line_end_d;
    logic             frame_end_q, frame_end_d;

    // Decode from the next count so outputs land in the same register stage as the counters.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (Enable) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
        hsync_d     = (hcnt_d >= HS_START && hcnt_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d     = (vcnt_d >= VS_START && vcnt_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        video_d     = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        line_end_d  = (hcnt_d == H_LAST);
        frame_end_d = (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
    end

    always_ff @(posedge pixelClk) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            video_q     <= 1'b1;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_q     <= video_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign hCount   = hcnt_q;
    assign vCount   = vcnt_q;
    assign hSync    = hsync_q;
    assign vSync    = vsync_q;
    assign videoOn  = video_q;
    assign lineEnd  = line_end_q;
    assign frameEnd = frame_end_q;

`ifdef VGA_TIMING_FRAMECOUNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // A frame completes when the last position is advanced past.
    always_comb begin
        fcnt_d = fcnt_q;
        if (Enable && frame_end_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge pixelClk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frameCount = fcnt_q;
`endif

endmodule
